// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing-error pulse
module uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial,
   output logic [7:0] parallel_out,
   output logic       data_valid,
   output logic       framing_error,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
   state_t state, state_n;
   logic rx_m, rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic [7:0] shreg, shreg_n;
   logic dv_n, fe_n;
   assign busy = state != IDLE;
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      dv_n      = 1'b0;
      fe_n      = 1'b0;
      case (state)
         IDLE: begin
            cnt_n     = '0;
            bit_idx_n = '0;
            state_n   = rx_s ? IDLE : START;
         end
         START: if (cnt == HALF_LAST) begin
            cnt_n   = '0;
            state_n = rx_s ? IDLE : DATA;
         end
         DATA: if (cnt == BIT_LAST) begin
            cnt_n     = '0;
            shreg_n   = {rx_s, shreg[7:1]};
            bit_idx_n = bit_idx + 1'b1;
            state_n   = bit_idx == 3'd7 ? STOP : DATA;
         end
         STOP: if (cnt == BIT_LAST) begin
            cnt_n   = '0;
            dv_n    = rx_s;
            fe_n    = !rx_s;
            state_n = rx_s ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: begin
            cnt_n   = '0;
            state_n = rx_s ? IDLE : WAIT_HIGH;
         end
         default: state_n = IDLE;
      endcase
   end
   // returning to IDLE at mid-stop-bit leaves half a bit to catch a back-to-back start
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {rx_s, rx_m}  <= 2'b11;
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         parallel_out  <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         {rx_s, rx_m}  <= {rx_m, rx_serial};
         state         <= state_n;
         cnt           <= cnt_n;
         bit_idx       <= bit_idx_n;
         shreg         <= shreg_n;
         data_valid    <= dv_n;
         framing_error <= fe_n;
         if (dv_n) parallel_out <= shreg;
      end
endmodule
